// File: rtl/jk_bank_ctrl_if.sv
// Command channel between board control logic and the JK bank sequencer.
// A command transfers on a rising clk edge where cmd_valid && cmd_ready; the master holds op/data/cnt stable while cmd_valid is high and cmd_ready is low.
interface jk_bank_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [7:0]       cmd_cnt;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_cnt,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_cnt,
    output cmd_ready
  );
endinterface

// File: rtl/jk_bank_ctrl.sv
// Sequencer for a bank of master-slave JK flip-flops: drives J/K, a two-phase bank
// clock and per-bit preset/clear, and checks the bank's Q against an expected-state model.
module jk_bank_ctrl #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             clr,
  jk_bank_ctrl_if.slave    cmd,
  output logic [WIDTH-1:0] ff_j,
  output logic [WIDTH-1:0] ff_k,
  output logic             ff_clk,
  output logic [WIDTH-1:0] ff_pre_n,
  output logic [WIDTH-1:0] ff_clr_n,
  input  logic [WIDTH-1:0] ff_q,
  output logic [WIDTH-1:0] exp_q,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_IDLE   = 3'd1,
    S_SETUP  = 3'd2,
    S_CLKHI  = 3'd3,
    S_CLKLO  = 3'd4,
    S_FPULSE = 3'd5,
    S_CHECK  = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  localparam logic [2:0] OP_HOLD   = 3'd0;
  localparam logic [2:0] OP_SET    = 3'd1;
  localparam logic [2:0] OP_RESET  = 3'd2;
  localparam logic [2:0] OP_TOGGLE = 3'd3;
  localparam logic [2:0] OP_LOAD   = 3'd4;
  localparam logic [2:0] OP_COUNT  = 3'd5;
  localparam logic [2:0] OP_SHIFTL = 3'd6;
  localparam logic [2:0] OP_FORCE  = 3'd7;

  localparam int            CW      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] SET_MAX = CW'(SETTLE - 1);

  state_t           state;
  logic             ready_r;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] data_r;
  logic [7:0]       iter_r;
  logic [CW-1:0]    cnt_r;

  logic [2*WIDTH-1:0] jk_acc;
  logic [2*WIDTH-1:0] jk_rep;
  logic [WIDTH-1:0]   next_exp;
  logic               mismatch;

  // J/K levels for one clocked step of op, given operand d and the bank state q it applies to.
  function automatic logic [2*WIDTH-1:0] jk_drive(input logic [2:0] op,
                                                   input logic [WIDTH-1:0] d,
                                                   input logic [WIDTH-1:0] q);
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             carry;
    j     = '0;
    k     = '0;
    carry = 1'b1;
    case (op)
      OP_SET:    j = d;
      OP_RESET:  k = d;
      OP_TOGGLE: begin j = d; k = d; end
      OP_LOAD:   begin j = d; k = ~d; end
      OP_COUNT: begin
        for (int i = 0; i < WIDTH; i++) begin
          j[i]  = carry;
          k[i]  = carry;
          carry = carry & q[i];
        end
      end
      OP_SHIFTL: begin
        j[0] = d[0];
        k[0] = ~d[0];
        for (int i = 1; i < WIDTH; i++) begin
          j[i] = q[i-1];
          k[i] = ~q[i-1];
        end
      end
      default: ;
    endcase
    return {j, k};
  endfunction

  always_comb begin
    jk_acc   = jk_drive(cmd.cmd_op, cmd.cmd_data, exp_q);
    next_exp = (op_r == OP_FORCE) ? data_r : ((ff_j & ~exp_q) | (~ff_k & exp_q));
    // Next COUNT iteration must see the state this CHECK produces, not the old register.
    jk_rep   = jk_drive(op_r, data_r, next_exp);
    mismatch = (ff_q != next_exp);
  end

  assign cmd.cmd_ready = ready_r;
  assign dbg_state     = state;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= S_INIT;
      ff_j     <= '0;
      ff_k     <= '0;
      ff_clk   <= 1'b0;
      ff_pre_n <= '1;
      ff_clr_n <= '0;
      exp_q    <= '0;
      ready_r  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      op_r     <= OP_HOLD;
      data_r   <= '0;
      iter_r   <= '0;
      cnt_r    <= '0;
    end else begin
      case (state)
        S_INIT: begin
          ff_clr_n <= '1;
          ready_r  <= 1'b1;
          state    <= S_IDLE;
        end
        S_IDLE: begin
          if (cmd.cmd_valid && ready_r) begin
            ready_r <= 1'b0;
            busy    <= 1'b1;
            op_r    <= cmd.cmd_op;
            data_r  <= cmd.cmd_data;
            iter_r  <= (cmd.cmd_op == OP_COUNT) ? cmd.cmd_cnt : 8'd0;
            cnt_r   <= SET_MAX;
            if (cmd.cmd_op == OP_FORCE) begin
              // Complementary levels: a bit never sees preset and clear together.
              ff_pre_n <= ~cmd.cmd_data;
              ff_clr_n <= cmd.cmd_data;
              state    <= S_FPULSE;
            end else begin
              {ff_j, ff_k} <= jk_acc;
              state        <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          if (cnt_r == '0) begin
            ff_clk <= 1'b1;
            cnt_r  <= SET_MAX;
            state  <= S_CLKHI;
          end else begin
            cnt_r <= cnt_r - 1'b1;
          end
        end
        S_CLKHI: begin
          if (cnt_r == '0) begin
            ff_clk <= 1'b0;
            cnt_r  <= SET_MAX;
            state  <= S_CLKLO;
          end else begin
            cnt_r <= cnt_r - 1'b1;
          end
        end
        S_FPULSE: begin
          if (cnt_r == '0) begin
            ff_pre_n <= '1;
            ff_clr_n <= '1;
            cnt_r    <= SET_MAX;
            state    <= S_CLKLO;
          end else begin
            cnt_r <= cnt_r - 1'b1;
          end
        end
        S_CLKLO: begin
          if (cnt_r == '0) begin
            state <= S_CHECK;
          end else begin
            cnt_r <= cnt_r - 1'b1;
          end
        end
        S_CHECK: begin
          if (mismatch) begin
            err   <= 1'b1;
            exp_q <= ff_q;
          end else begin
            exp_q <= next_exp;
          end
          if (mismatch || (iter_r == 8'd0)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            iter_r       <= iter_r - 8'd1;
            {ff_j, ff_k} <= jk_rep;
            cnt_r        <= SET_MAX;
            state        <= S_SETUP;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          ready_r <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Directed bench for jk_bank_ctrl with a behavioural master-slave JK bank on the feedback path.
module tb_jk_bank_ctrl;
  localparam int W = 4;
  localparam int S = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  jk_bank_ctrl_if #(.WIDTH(W)) cmd_if ();

  logic [W-1:0] ff_j, ff_k, ff_pre_n, ff_clr_n, ff_q, exp_state;
  logic         ff_clk, busy, done, err;
  logic [2:0]   dbg_state;

  jk_bank_ctrl #(.WIDTH(W), .SETTLE(S)) dut (
    .clk       (clk),
    .clr       (clr),
    .cmd       (cmd_if),
    .ff_j      (ff_j),
    .ff_k      (ff_k),
    .ff_clk    (ff_clk),
    .ff_pre_n  (ff_pre_n),
    .ff_clr_n  (ff_clr_n),
    .ff_q      (ff_q),
    .exp_q     (exp_state),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- JK bank model ----------------
  logic [W-1:0] bank_q     = '0;
  logic [W-1:0] bank_m     = '0;
  logic [W-1:0] fault_mask = '0;
  logic         ff_clk_d   = 1'b0;

  function automatic logic [W-1:0] jk_next(input logic [W-1:0] q, input logic [W-1:0] j,
                                           input logic [W-1:0] k);
    return (j & ~q) | (~k & q);
  endfunction

  always @(negedge clk) begin
    if (ff_clk && !ff_clk_d) bank_m <= jk_next(bank_q, ff_j, ff_k);
    if (!ff_clk && ff_clk_d) bank_q <= (bank_m & ff_clr_n) | ~ff_pre_n;
    else                     bank_q <= (bank_q & ff_clr_n) | ~ff_pre_n;
    ff_clk_d <= ff_clk;
  end

  assign ff_q = bank_q & ~fault_mask;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] seen_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  int lat_done, pulses, hi_cyc, done_cnt, overlap, jk_bad, pre_cyc, both_low;
  logic         busy_first;
  logic [W-1:0] first_j, first_k, first_pre, first_clr;

  task automatic issue(input logic [2:0] op, input logic [W-1:0] d, input logic [7:0] c);
    int guard;
    guard = 0;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = d;
    cmd_if.cmd_cnt   = c;
    while (cmd_if.cmd_ready !== 1'b1 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) check("accept_timeout", 32'(guard), 32'd0);
    @(posedge clk); #1;
    cmd_if.cmd_valid = 1'b0;
  endtask

  // Called in the first cycle after the accept edge; returns once the controller is idle again.
  task automatic collect();
    logic         prev_clk;
    logic [W-1:0] prev_exp, prev_j, prev_k;
    int           lat;
    bit           finished;
    lat = 1; finished = 0;
    pulses = 0; hi_cyc = 0; done_cnt = 0; overlap = 0; jk_bad = 0; pre_cyc = 0; both_low = 0;
    lat_done = 0;
    seen_q.delete();
    busy_first = busy;
    first_j = ff_j; first_k = ff_k; first_pre = ff_pre_n; first_clr = ff_clr_n;
    prev_clk = 1'b0; prev_exp = exp_state; prev_j = ff_j; prev_k = ff_k;
    for (int g = 0; g < 1000; g++) begin
      if (ff_clk && !prev_clk) pulses++;
      if (ff_clk) begin
        hi_cyc++;
        if (ff_j !== prev_j || ff_k !== prev_k) jk_bad++;
      end
      if (ff_pre_n != '1) pre_cyc++;
      if ((~ff_pre_n & ~ff_clr_n) != '0) both_low++;
      if (exp_state != prev_exp) seen_q.push_back(exp_state);
      if (done) begin
        done_cnt++;
        if (cmd_if.cmd_ready) overlap++;
        if (done_cnt == 1) lat_done = lat;
      end
      prev_clk = ff_clk; prev_exp = exp_state; prev_j = ff_j; prev_k = ff_k;
      if (cmd_if.cmd_ready && done_cnt > 0) begin
        finished = 1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    if (!finished) check("done_timeout", 32'(lat), 32'd0);
  endtask

  task automatic run(input logic [2:0] op, input logic [W-1:0] d, input logic [7:0] c);
    issue(op, d, c);
    collect();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int g;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 3'd0;
    cmd_if.cmd_data  = '0;
    cmd_if.cmd_cnt   = 8'd0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_clr_n", ff_clr_n, 4'b0000);
    check("rst_pre_n", ff_pre_n, 4'b1111);
    check("rst_exp",   exp_state, 4'b0000);
    check("rst_ready", cmd_if.cmd_ready, 1'b0);
    check("rst_busy",  busy, 1'b0);
    check("rst_done",  done, 1'b0);
    check("rst_err",   err, 1'b0);
    check("rst_ffclk", ff_clk, 1'b0);
    check("rst_state", dbg_state, 3'd0);

    clr = 1'b1;
    @(posedge clk); #1;
    check("init_clr_n", ff_clr_n, 4'b1111);
    check("init_ready", cmd_if.cmd_ready, 1'b1);
    check("init_state", dbg_state, 3'd1);
    check("init_bank",  ff_q, 4'b0000);

    // LOAD 1010
    run(3'd4, 4'b1010, 8'd0);
    check("load_j",     first_j, 4'b1010);
    check("load_k",     first_k, 4'b0101);
    check("load_busy",  busy_first, 1'b1);
    check("load_hi",    hi_cyc, 2);
    check("load_pulse", pulses, 1);
    check("load_lat",   lat_done, 8);
    check("load_exp",   exp_state, 4'b1010);
    check("load_q",     ff_q, 4'b1010);
    check("load_err",   err, 1'b0);
    check("load_ndone", done_cnt, 1);
    check("load_ovl",   overlap, 0);
    check("load_jk",    jk_bad, 0);

    run(3'd3, 4'b0011, 8'd0);
    check("toggle_exp", exp_state, 4'b1001);
    run(3'd1, 4'b0100, 8'd0);
    check("set_exp", exp_state, 4'b1101);
    run(3'd2, 4'b1000, 8'd0);
    check("reset_exp", exp_state, 4'b0101);
    run(3'd0, 4'b1111, 8'd0);
    check("hold_exp",   exp_state, 4'b0101);
    check("hold_pulse", pulses, 1);
    check("hold_jk",    {first_j, first_k}, 8'h00);

    // COUNT x8 from 1110
    run(3'd4, 4'b1110, 8'd0);
    check("cnt_pre", exp_state, 4'b1110);
    exp_q = '{4'b1111, 4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110};
    run(3'd5, 4'b0000, 8'd7);
    check("cnt_pulse", pulses, 8);
    check("cnt_lat",   lat_done, 57);
    check("cnt_ndone", done_cnt, 1);
    check("cnt_nseq",  seen_q.size(), 8);
    check("cnt_jk",    jk_bad, 0);
    while (exp_q.size() > 0 && seen_q.size() > 0)
      check("cnt_seq", seen_q.pop_front(), exp_q.pop_front());
    check("cnt_err", err, 1'b0);

    // SHIFTL from 0001
    run(3'd4, 4'b0001, 8'd0);
    run(3'd6, 4'b0001, 8'd0);
    check("shl1", exp_state, 4'b0011);
    run(3'd6, 4'b0001, 8'd0);
    check("shl2", exp_state, 4'b0111);
    run(3'd6, 4'b0001, 8'd0);
    check("shl3", exp_state, 4'b1111);

    // FORCE 0110
    run(3'd7, 4'b0110, 8'd0);
    check("frc_pre",   first_pre, 4'b1001);
    check("frc_clr",   first_clr, 4'b0110);
    check("frc_cyc",   pre_cyc, 2);
    check("frc_pulse", pulses, 0);
    check("frc_both",  both_low, 0);
    check("frc_lat",   lat_done, 6);
    check("frc_exp",   exp_state, 4'b0110);
    check("frc_q",     ff_q, 4'b0110);
    check("frc_err",   err, 1'b0);

    // Fault: bit 2 stuck low during COUNT from 0011
    run(3'd4, 4'b0011, 8'd0);
    fault_mask = 4'b0100;
    run(3'd5, 4'b0000, 8'd9);
    check("flt_err",   err, 1'b1);
    check("flt_exp",   exp_state, 4'b0000);
    check("flt_pulse", pulses, 1);
    check("flt_lat",   lat_done, 8);
    check("flt_ndone", done_cnt, 1);
    fault_mask = 4'b0000;

    // clr during CLKHI of COUNT, with a command held pending
    issue(3'd5, 4'b0000, 8'd3);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = 3'd4;
    cmd_if.cmd_data  = 4'b0101;
    cmd_if.cmd_cnt   = 8'd0;
    g = 0;
    while (!ff_clk && g < 20) begin
      check("pend_ready", cmd_if.cmd_ready, 1'b0);
      @(posedge clk); #1;
      g++;
    end
    if (g >= 20) check("clkhi_timeout", 32'(g), 32'd0);
    #1 clr = 1'b0;
    #1;
    check("abort_ffclk", ff_clk, 1'b0);
    check("abort_clr_n", ff_clr_n, 4'b0000);
    check("abort_exp",   exp_state, 4'b0000);
    check("abort_busy",  busy, 1'b0);
    check("abort_ready", cmd_if.cmd_ready, 1'b0);
    check("abort_err",   err, 1'b0);
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    check("rel_state", dbg_state, 3'd1);
    check("rel_ready", cmd_if.cmd_ready, 1'b1);
    check("rel_bank",  ff_q, 4'b0000);
    @(posedge clk); #1;
    cmd_if.cmd_valid = 1'b0;
    check("pend_busy",  busy, 1'b1);
    check("pend_state", dbg_state, 3'd2);
    check("pend_j",     ff_j, 4'b0101);
    collect();
    check("pend_exp", exp_state, 4'b0101);
    check("pend_lat", lat_done, 8);
    check("pend_err", err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
